fir_coef_loader: RTL and testbench

FIR_COEF_LOADER -- requirements
Module: fir_coef_loader

---
 rtl/fir_pkg.sv | 17 +
 rtl/fir_coef_ram.sv | 48 ++++
 rtl/fir_coef_loader.sv | 156 +++++++++++++++
 tb/tb_fir_coef_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR coefficient loader.
// The optional readback port is enabled by defining FIR_COEF_READBACK_EN.
package fir_pkg;

  localparam int COEF_W_DEFAULT = 25;

  localparam int ERR_LEN_BIT = 0;
  localparam int ERR_REJ_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOAD   = 2'd2,
    ST_FINISH = 2'd3
  } fir_state_e;

endpackage

// File: rtl/fir_coef_ram.sv
// Staging coefficient RAM: one write port, one enabled synchronous loader read port,
// and a free-running readback port when FIR_COEF_READBACK_EN is defined.
module fir_coef_ram #(
  parameter int LEN    = 21,
  parameter int COEF_W = 25
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(LEN)-1:0]   wr_addr,
  input  logic [COEF_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(LEN)-1:0]   rd_addr,
  output logic [COEF_W-1:0]        rd_data
`ifdef FIR_COEF_READBACK_EN
  ,
  input  logic [$clog2(LEN)-1:0]   rb_addr,
  output logic [COEF_W-1:0]        rb_data
`endif
);

  logic [COEF_W-1:0] mem_q [LEN];
  logic [COEF_W-1:0] rd_data_q;

  // Array contents are deliberately not reset; software reloads after reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // The read register doubles as the loader's cfg_din flop, so it resets and holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

`ifdef FIR_COEF_READBACK_EN
  logic [COEF_W-1:0] rb_data_q;

  always_ff @(posedge clk) begin
    rb_data_q <= mem_q[rb_addr];
  end

  assign rb_data = rb_data_q;
`endif

endmodule

// File: rtl/fir_coef_loader.sv
// Stages FIR coefficients from the CPU and shifts them into the filter's coefficient chain.
// Defining FIR_COEF_READBACK_EN adds the rd_addr/rd_data readback port.
//
// state     | meaning
// ST_IDLE   | waiting for start; CPU writes accepted
// ST_CHECK  | compare reported tap count, prefetch last staging entry
// ST_LOAD   | one cfg_ce shift per cycle, entry LEN-1 down to entry 0
// ST_FINISH | done pulse, then back to idle
module fir_coef_loader
  import fir_pkg::*;
#(
  parameter int LEN    = 21,
  parameter int COEF_W = COEF_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(LEN)-1:0]   wr_addr,
  input  logic [COEF_W-1:0]        wr_data,
  output logic                     wr_ack,
  input  logic                     start,
  input  logic [31:0]              len_in,
  output logic [COEF_W-1:0]        cfg_din,
  output logic                     cfg_ce,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               err,
  input  logic                     err_clr
`ifdef FIR_COEF_READBACK_EN
  ,
  input  logic [$clog2(LEN)-1:0]   rd_addr,
  output logic [COEF_W-1:0]        rd_data
`endif
);

  localparam int            AW       = $clog2(LEN);
  localparam logic [AW-1:0] LAST_IDX = AW'(LEN - 1);

  fir_state_e    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          cfg_ce_q, cfg_ce_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          wr_ack_q, wr_ack_d;
  logic [1:0]    err_q, err_d;

  logic          wr_ok;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cfg_ce_d    = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ram_rd_en   = 1'b0;
    ram_rd_addr = idx_q;

    wr_ok    = wr_en && !busy_q && (wr_addr <= LAST_IDX);
    wr_ack_d = wr_ok;

    // Clear first so that any error event on the same cycle still sets its bit.
    err_d = err_clr ? 2'b00 : err_q;
    if (wr_en && !wr_ok) err_d[ERR_REJ_BIT] = 1'b1;
    if (start && busy_q) err_d[ERR_REJ_BIT] = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CHECK;
          busy_d  = 1'b1;
        end
      end
      ST_CHECK: begin
        if (len_in == 32'(LEN)) begin
          state_d     = ST_LOAD;
          cfg_ce_d    = 1'b1;
          ram_rd_en   = 1'b1;
          ram_rd_addr = LAST_IDX;
          idx_d       = LAST_IDX;
        end else begin
          state_d            = ST_IDLE;
          busy_d             = 1'b0;
          err_d[ERR_LEN_BIT] = 1'b1;
        end
      end
      ST_LOAD: begin
        // idx_q is the entry currently on cfg_din; fetch the next one a cycle ahead.
        if (idx_q != '0) begin
          cfg_ce_d    = 1'b1;
          ram_rd_en   = 1'b1;
          ram_rd_addr = idx_q - 1'b1;
          idx_d       = idx_q - 1'b1;
        end else begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cfg_ce_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_ack_q <= 1'b0;
      err_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cfg_ce_q <= cfg_ce_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wr_ack_q <= wr_ack_d;
      err_q    <= err_d;
    end
  end

  fir_coef_ram #(
    .LEN    (LEN),
    .COEF_W (COEF_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_ok),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (cfg_din)
`ifdef FIR_COEF_READBACK_EN
    ,
    .rb_addr (rd_addr),
    .rb_data (rd_data)
`endif
  );

  assign cfg_ce = cfg_ce_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign wr_ack = wr_ack_q;
  assign err    = err_q;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader: table-driven staging writes plus load-sequence scenarios.
// Readback checks are compiled in when FIR_COEF_READBACK_EN is defined.
module tb_fir_coef_loader;

  localparam int LEN    = 21;
  localparam int COEF_W = 25;
  localparam int AW     = 5;

  logic              clk;
  logic              reset;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [COEF_W-1:0] wr_data;
  logic              wr_ack;
  logic              start;
  logic [31:0]       len_in;
  logic [COEF_W-1:0] cfg_din;
  logic              cfg_ce;
  logic              busy;
  logic              done;
  logic [1:0]        err;
  logic              err_clr;
`ifdef FIR_COEF_READBACK_EN
  logic [AW-1:0]     rd_addr;
  logic [COEF_W-1:0] rd_data;
`endif

  fir_coef_loader #(.LEN(LEN), .COEF_W(COEF_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_ack  (wr_ack),
    .start   (start),
    .len_in  (len_in),
    .cfg_din (cfg_din),
    .cfg_ce  (cfg_ce),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .err_clr (err_clr)
`ifdef FIR_COEF_READBACK_EN
    ,
    .rd_addr (rd_addr),
    .rd_data (rd_data)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [AW-1:0]     addr;
    logic [COEF_W-1:0] data;
    logic              clr;
    logic              exp_ack;
    logic [1:0]        exp_err;
  } wr_vec_t;

  localparam int NVEC = LEN + 3;

  wr_vec_t           vecs [NVEC];
  logic [COEF_W-1:0] model [LEN];
  int                tests;
  int                fails;

  task automatic check(input string what, input logic ok, input string got, input string want);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %s, expected %s", what, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  // Start is driven in cycle 0; outputs are sampled mid-cycle for cycles 1..LEN+3.
  task automatic run_load(input string name, input int wr_cyc, input logic [AW-1:0] wr_a,
                          input logic [COEF_W-1:0] wr_d, input int re_cyc, input int abort_cyc);
    logic              exp_ce, exp_busy, exp_done, exp_ack, ok;
    logic [COEF_W-1:0] exp_din;
    len_in = 32'(LEN);
    start  = 1'b1;
    if (wr_cyc == 0) begin
      wr_en   = 1'b1;
      wr_addr = wr_a;
      wr_data = wr_d;
      model[wr_a] = wr_d;
    end
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    for (int c = 1; c <= LEN + 3; c++) begin
      if (c == wr_cyc) begin
        wr_en   = 1'b1;
        wr_addr = wr_a;
        wr_data = wr_d;
      end
      if (c == re_cyc) start = 1'b1;
      if (c == abort_cyc) reset = 1'b0;
      @(negedge clk);
      if (c == abort_cyc) begin
        check($sformatf("%s abort c%0d", name, c),
              cfg_ce == 1'b0 && busy == 1'b0 && done == 1'b0 && err == 2'b00,
              $sformatf("ce=%b busy=%b done=%b err=%b", cfg_ce, busy, done, err),
              "ce=0 busy=0 done=0 err=00");
        reset = 1'b1;
        tick();
        return;
      end
      exp_ce   = (c >= 2 && c <= LEN + 1);
      exp_busy = (c <= LEN + 2);
      exp_done = (c == LEN + 2);
      exp_ack  = (c == 1 && wr_cyc == 0);
      exp_din  = exp_ce ? model[LEN - 1 - (c - 2)] : model[0];
      ok = (cfg_ce == exp_ce) && (busy == exp_busy) && (done == exp_done) &&
           (wr_ack == exp_ack) && (c == 1 || cfg_din == exp_din);
      check($sformatf("%s c%0d", name, c), ok,
            $sformatf("ce=%b din=%h busy=%b done=%b ack=%b", cfg_ce, cfg_din, busy, done, wr_ack),
            $sformatf("ce=%b din=%h busy=%b done=%b ack=%b", exp_ce, exp_din, exp_busy, exp_done, exp_ack));
      if (wr_cyc > 0 && c == wr_cyc + 1)
        check($sformatf("%s wr reject err", name), err[1] == 1'b1,
              $sformatf("err=%b", err), "err[1]=1");
      if (re_cyc > 0 && c == re_cyc + 1)
        check($sformatf("%s start reject err", name), err[1] == 1'b1,
              $sformatf("err=%b", err), "err[1]=1");
      tick();
      wr_en = 1'b0;
      start = 1'b0;
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start   = 1'b0;
    len_in  = 32'(LEN);
    err_clr = 1'b0;
`ifdef FIR_COEF_READBACK_EN
    rd_addr = '0;
`endif

    for (int k = 0; k < LEN; k++) begin
      vecs[k] = '{addr: AW'(k), data: COEF_W'(k + 1), clr: 1'b0, exp_ack: 1'b1, exp_err: 2'b00};
      model[k] = '0;
    end
    vecs[LEN]     = '{addr: 5'd21, data: 25'h0155555, clr: 1'b0, exp_ack: 1'b0, exp_err: 2'b10};
    vecs[LEN + 1] = '{addr: 5'd31, data: 25'h0000077, clr: 1'b1, exp_ack: 1'b0, exp_err: 2'b10};
    vecs[LEN + 2] = '{addr: 5'd0,  data: 25'h0000001, clr: 1'b1, exp_ack: 1'b1, exp_err: 2'b00};

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst cfg_ce",  cfg_ce == 1'b0,  $sformatf("%b", cfg_ce),  "0");
    check("rst cfg_din", cfg_din == '0,   $sformatf("%h", cfg_din), "0");
    check("rst busy",    busy == 1'b0,    $sformatf("%b", busy),    "0");
    check("rst done",    done == 1'b0,    $sformatf("%b", done),    "0");
    check("rst wr_ack",  wr_ack == 1'b0,  $sformatf("%b", wr_ack),  "0");
    check("rst err",     err == 2'b00,    $sformatf("%b", err),     "00");
    reset = 1'b1;
    tick();

    // Staging writes from the vector table
    for (int i = 0; i < NVEC; i++) begin
      wr_en   = 1'b1;
      wr_addr = vecs[i].addr;
      wr_data = vecs[i].data;
      err_clr = vecs[i].clr;
      tick();
      wr_en   = 1'b0;
      err_clr = 1'b0;
      if (vecs[i].exp_ack) model[vecs[i].addr] = vecs[i].data;
      @(negedge clk);
      check($sformatf("wr vec %0d", i),
            wr_ack == vecs[i].exp_ack && err == vecs[i].exp_err,
            $sformatf("ack=%b err=%b", wr_ack, err),
            $sformatf("ack=%b err=%b", vecs[i].exp_ack, vecs[i].exp_err));
      tick();
    end

    // Full load: cfg_din = 21,20,...,1
    run_load("load", -1, '0, '0, -1, -1);
    @(negedge clk);
    check("load err", err == 2'b00, $sformatf("%b", err), "00");
    tick();

    // Length mismatch
    len_in = 32'd20;
    start  = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("lenmis c1", busy == 1'b1 && cfg_ce == 1'b0,
          $sformatf("busy=%b ce=%b", busy, cfg_ce), "busy=1 ce=0");
    tick();
    @(negedge clk);
    check("lenmis c2", busy == 1'b0 && cfg_ce == 1'b0 && err == 2'b01,
          $sformatf("busy=%b ce=%b err=%b", busy, cfg_ce, err), "busy=0 ce=0 err=01");
    tick();
    @(negedge clk);
    check("lenmis c3", cfg_ce == 1'b0 && done == 1'b0,
          $sformatf("ce=%b done=%b", cfg_ce, done), "ce=0 done=0");
    tick();
    clear_err();
    @(negedge clk);
    check("err_clr", err == 2'b00, $sformatf("%b", err), "00");
    tick();

    // Write dropped during a load
    run_load("wrbusy", 5, 5'd0, 25'h1FFFFFF, -1, -1);
    clear_err();

    // Start while busy, and start on the done cycle
    run_load("rebusy", -1, '0, '0, 7, -1);
    clear_err();
    run_load("redone", -1, '0, '0, LEN + 2, -1);
    clear_err();

    // Reset mid-load, then a complete load
    run_load("abort", -1, '0, '0, -1, 10);
    @(negedge clk);
    check("abort idle", busy == 1'b0 && cfg_ce == 1'b0 && err == 2'b00,
          $sformatf("busy=%b ce=%b err=%b", busy, cfg_ce, err), "busy=0 ce=0 err=00");
    tick();
    run_load("reload", -1, '0, '0, -1, -1);

    // Write and start on the same cycle
    run_load("wrstart", 0, 5'd20, 25'h001ABCD, -1, -1);

`ifdef FIR_COEF_READBACK_EN
    wr_en   = 1'b1;
    wr_addr = 5'd3;
    wr_data = 25'h0000080;
    model[3] = 25'h0000080;
    tick();
    wr_en = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rd_addr = 5'd3;
    tick();
    @(negedge clk);
    check("readback", rd_data == 25'h0000080 && busy == 1'b1,
          $sformatf("rd=%h busy=%b", rd_data, busy), "rd=0000080 busy=1");
    tick();
    begin
      int budget;
      budget = 0;
      while (busy && budget < 100) begin
        tick();
        budget++;
      end
      check("readback drain", busy == 1'b0, $sformatf("busy=%b", busy), "busy=0");
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
